// File: rtl/spi_nor_flash_responder.sv
// SPI NOR flash target (mode 0, single-bit) answering READ, RDID, RDSR, WREN, WRDI and PP,
// with pins oversampled on i_clock and data backed by an external synchronous byte memory.
module spi_nor_flash_responder #(
    parameter int unsigned MEM_AW   = 12,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              fMclk,
    input  logic              fChipSel,
    input  logic              fMosi,
    output logic              fMiso,
    output logic [MEM_AW-1:0] memAddr,
    output logic              memRdEn,
    input  logic [7:0]        memRdData,
    output logic              memWrEn,
    output logic [7:0]        memWrData,
    output logic [2:0]        dbgState
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCmd    = 3'd1,
        StAddr   = 3'd2,
        StRd     = 3'd3,
        StId     = 3'd4,
        StSr     = 3'd5,
        StPp     = 3'd6,
        StIgnore = 3'd7
    } state_e;

    state_e            state;
    logic [2:0]        mclkSync;
    logic [1:0]        csSync;
    logic [1:0]        mosiSync;
    logic              csPrev;
    logic [2:0]        bitCnt;
    logic [7:0]        rxShift;
    logic [7:0]        txShift;
    logic [7:0]        txByte;
    logic              byteDone;
    logic              wel;
    logic              armWren;
    logic              armWrdi;
    logic              ppWrote;
    logic              isRead;
    logic [1:0]        addrCnt;
    logic [15:0]       addrHi;
    logic [MEM_AW-1:0] rdAddr;
    logic [MEM_AW-1:0] wrAddr;
    logic              rdPend;
    logic [1:0]        idIdx;

    logic        mclkRise;
    logic        mclkFall;
    logic        csHigh;
    logic [23:0] flashAddr;
    logic        unusedAddrBits;

    // mclkSync[1] and mosiSync[1] have matching latency, so the sampled bit lines up with the edge.
    assign mclkRise       = mclkSync[1] & ~mclkSync[2];
    assign mclkFall       = ~mclkSync[1] & mclkSync[2];
    assign csHigh         = csSync[1];
    assign flashAddr      = {addrHi, rxShift};
    assign unusedAddrBits = ^flashAddr[23:MEM_AW];
    assign dbgState       = state;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state     <= StIdle;
            mclkSync  <= '0;
            csSync    <= '0;
            mosiSync  <= '0;
            csPrev    <= 1'b0;
            bitCnt    <= '0;
            rxShift   <= '0;
            txShift   <= '0;
            txByte    <= '0;
            byteDone  <= 1'b0;
            wel       <= 1'b0;
            armWren   <= 1'b0;
            armWrdi   <= 1'b0;
            ppWrote   <= 1'b0;
            isRead    <= 1'b0;
            addrCnt   <= '0;
            addrHi    <= '0;
            rdAddr    <= '0;
            wrAddr    <= '0;
            rdPend    <= 1'b0;
            idIdx     <= '0;
            fMiso     <= 1'b0;
            memAddr   <= '0;
            memRdEn   <= 1'b0;
            memWrEn   <= 1'b0;
            memWrData <= '0;
        end else begin
            mclkSync <= {mclkSync[1:0], fMclk};
            csSync   <= {csSync[0], fChipSel};
            mosiSync <= {mosiSync[0], fMosi};
            csPrev   <= csHigh;
            memRdEn  <= 1'b0;
            memWrEn  <= 1'b0;
            byteDone <= 1'b0;
            rdPend   <= memRdEn;
            if (rdPend) txByte <= memRdData;

            if (csHigh) begin
                state   <= StIdle;
                bitCnt  <= '0;
                fMiso   <= 1'b0;
                txByte  <= '0;
                addrCnt <= '0;
                rdPend  <= 1'b0;
                // Commit actions armed by fully received opcodes take effect on deselect.
                if (!csPrev) begin
                    if (armWren) wel <= 1'b1;
                    if (armWrdi || ppWrote) wel <= 1'b0;
                end
                armWren <= 1'b0;
                armWrdi <= 1'b0;
                ppWrote <= 1'b0;
            end else begin
                if (state == StIdle) state <= StCmd;

                if (mclkRise) begin
                    rxShift <= {rxShift[6:0], mosiSync[1]};
                    bitCnt  <= bitCnt + 3'd1;
                    if (bitCnt == 3'd7) byteDone <= 1'b1;
                end

                if (mclkFall) begin
                    if (state == StIgnore) begin
                        fMiso <= 1'b0;
                    end else if (bitCnt == 3'd0) begin
                        fMiso   <= txByte[7];
                        txShift <= {txByte[6:0], 1'b0};
                    end else begin
                        fMiso   <= txShift[7];
                        txShift <= {txShift[6:0], 1'b0};
                    end
                end

                if (byteDone) begin
                    case (state)
                        StCmd: begin
                            case (rxShift)
                                8'h03: begin
                                    isRead <= 1'b1;
                                    state  <= StAddr;
                                end
                                8'h9F: begin
                                    txByte <= JEDEC_ID[23:16];
                                    idIdx  <= 2'd1;
                                    state  <= StId;
                                end
                                8'h05: begin
                                    txByte <= {6'b0, wel, 1'b0};
                                    state  <= StSr;
                                end
                                8'h06: begin
                                    armWren <= 1'b1;
                                    state   <= StIgnore;
                                end
                                8'h04: begin
                                    armWrdi <= 1'b1;
                                    state   <= StIgnore;
                                end
                                8'h02: begin
                                    isRead <= 1'b0;
                                    state  <= wel ? StAddr : StIgnore;
                                end
                                default: state <= StIgnore;
                            endcase
                        end
                        StAddr: begin
                            addrHi  <= {addrHi[7:0], rxShift};
                            addrCnt <= addrCnt + 2'd1;
                            if (addrCnt == 2'd2) begin
                                if (isRead) begin
                                    memAddr <= flashAddr[MEM_AW-1:0];
                                    memRdEn <= 1'b1;
                                    rdAddr  <= flashAddr[MEM_AW-1:0] + MEM_AW'(1);
                                    state   <= StRd;
                                end else begin
                                    wrAddr <= flashAddr[MEM_AW-1:0];
                                    state  <= StPp;
                                end
                            end
                        end
                        StRd: begin
                            memAddr <= rdAddr;
                            memRdEn <= 1'b1;
                            rdAddr  <= rdAddr + MEM_AW'(1);
                        end
                        StId: begin
                            case (idIdx)
                                2'd1: begin
                                    txByte <= JEDEC_ID[15:8];
                                    idIdx  <= 2'd2;
                                end
                                2'd2: begin
                                    txByte <= JEDEC_ID[7:0];
                                    idIdx  <= 2'd3;
                                end
                                default: txByte <= 8'h00;
                            endcase
                        end
                        StPp: begin
                            memAddr     <= wrAddr;
                            memWrEn     <= 1'b1;
                            memWrData   <= rxShift;
                            // Page wrap: only the low byte of the address advances.
                            wrAddr[7:0] <= wrAddr[7:0] + 8'd1;
                            ppWrote     <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/spi_nor_flash_responder.md
Name: spi_nor_flash_responder

Overview:
Synthesizable SPI NOR flash target (mode 0, single-bit I/O) that answers the existing flash controller over fMclk/fChipSel/fMosi/fMiso. It oversamples the SPI pins on the system clock, decodes the command subset the controller issues, and backs reads and page programs with an external synchronous byte memory. It is used for on-board loopback bring-up and as a bench target, and its state is exported for logic-analyzer probing.

Parameters:
MEM_AW, 12, backing memory address width; flash address bits above MEM_AW-1 are ignored.
JEDEC_ID, 24'hEF4016, manufacturer/type/capacity bytes returned MSB-first by 0x9F.

Ports:
i_clock  in  1  system clock; must be at least 8x the fMclk frequency
i_reset_n  in  1  synchronous active-low reset
fMclk  in  1  SPI clock from the controller, asynchronous
fChipSel  in  1  SPI chip select, active low, asynchronous
fMosi  in  1  controller-to-flash data, asynchronous
fMiso  out  1  flash-to-controller data, registered
memAddr  out  MEM_AW  backing memory byte address
memRdEn  out  1  one-cycle read strobe; memRdData is valid the following cycle
memRdData  in  8  backing memory read data
memWrEn  out  1  one-cycle write strobe
memWrData  out  8  write data, valid with memWrEn
dbgState  out  3  current state encoding, for probing

Behaviour:
- Reset is synchronous and active-low; one clock, i_clock. With i_reset_n low, every output is 0, state is IDLE, bitCnt is 0, WEL is 0, and the shift registers are 0. Reset asserted mid-transaction aborts it, and no further memory strobe is issued.
- fMclk, fChipSel and fMosi each pass through a 2-flop synchronizer. A third flop on fMclk provides rise/fall edge detection. fMosi is sampled from the synchronized copy aligned with the fMclk rise.
- Synchronized fChipSel high forces IDLE, bitCnt=0 and fMiso=0 in the same cycle, taking priority over any edge that cycle. On the transition to high, pending commit actions run: WREN (0x06) sets WEL, WRDI (0x04) clears WEL, and a PP that wrote at least 1 byte clears WEL. These commit actions run only if the full 8-bit opcode was received.
- Rising fMclk with CS low: rxShift <= {rxShift[6:0], mosi} and bitCnt++. When bitCnt reaches 8 it wraps to 0 and raises byteDone for 1 cycle, carrying the complete byte.
- Falling fMclk with CS low: if bitCnt==0, fMiso <= txByte[7] and txShift <= {txByte[6:0],0}. Otherwise fMiso <= txShift[7] and txShift shifts left by 1. txByte defaults to 0x00.
- States and transitions on byteDone:
  - IDLE/CMD: CS falling enters CMD.
  - From CMD:
    - 0x03 goes to ADDR.
    - 0x9F goes to ID; txByte = JEDEC_ID[23:16].
    - 0x05 goes to SR; txByte = {6'b0, WEL, WIP=0}.
    - 0x06 or 0x04 goes to IGNORE, with commit armed.
    - 0x02 goes to ADDR if WEL=1, else to IGNORE.
    - Any other opcode goes to IGNORE.
  - ADDR: collects 3 bytes MSB-first into a 24-bit address. After byte 3:
    - For a read: memAddr = addr[MEM_AW-1:0], memRdEn=1, rdAddr <= addr+1 (mod 2^MEM_AW), go to RD.
    - For PP: wrAddr <= addr, go to PP.
  - Read latency: txByte <= memRdData 1 cycle after memRdEn.
  - RD: on each byteDone, issue memRdEn at rdAddr and increment rdAddr, so data streams without a limit. The address wraps 2^MEM_AW-1 -> 0.
  - ID: byteDone steps through JEDEC_ID bytes [15:8], [7:0], then 0x00 for all later bytes.
  - SR: the status byte repeats for as long as CS is held low.
  - PP: each byteDone issues memWrEn with memAddr=wrAddr and memWrData=the received byte. Then wrAddr[7:0] increments with a 256-byte page wrap; the upper bits are held.
  - IGNORE: fMiso is 0 and no strobes are issued until CS goes high.
- CS deassert mid-byte discards the partial byte: no strobe and no commit. A read prefetched but never shifted out is dropped.
- dbgState encoding: IDLE=0, CMD=1, ADDR=2, RD=3, ID=4, SR=5, PP=6, IGNORE=7.
- Timing margin: at 8x oversampling, byteDone occurs ≤3 cycles after the real rising edge. txByte is loaded ≤2 cycles later, before the next detected falling edge (≥4 cycles after the rise).

Test Plan:
- JEDEC ID: opcode 0x9F, then clock 4 bytes -> MISO bytes are EF, 40, 16, 00; no memory strobes.
- Streaming read: memory[0x010..0x013] preloaded with A1 B2 C3 D4; send 03 00 00 10 then 4 dummy bytes -> MISO returns A1 B2 C3 D4; memRdEn pulses 4 times (5 if the last byteDone prefetches 0x014).
- Read wrap: read at 0x000FFF with 2 dummy bytes -> mem[0xFFF] then mem[0x000]. Flash address 0x123FFF gives the same result (upper bits ignored).
- WEL sequence:
  - RDSR gives 0x00.
  - Send 06, deassert CS, then RDSR -> 0x02.
  - Send 04, deassert CS, then RDSR -> 0x00.
  - Send 06 with CS dropped after 5 bits -> RDSR still 0x00.
- Page program: without WREN, 02 00 00 FE 11 22 -> no memWrEn, state IGNORE. With WREN first, 02 00 01 FE 11 22 33 -> writes to 0x1FE=11, 0x1FF=22, 0x100=33 (page wrap). After CS deassert, RDSR = 0x00.
- Abort and reset: CS deasserted during the 2nd address byte -> IDLE and no strobe; the next 9F command works normally. i_reset_n pulsed low during an RD stream -> fMiso=0, all strobes 0, dbgState=0 on the next cycle.
